// File: rtl/edge_pkg.sv
// Shared definitions for the edge detector bank: detect-mode encodings,
// default parameter values and the mode decode helper.
package edge_pkg;

    localparam logic [1:0] MODE_OFF  = 2'b00;
    localparam logic [1:0] MODE_RISE = 2'b01;
    localparam logic [1:0] MODE_FALL = 2'b10;
    localparam logic [1:0] MODE_BOTH = 2'b11;

    localparam int DEF_CH          = 8;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_FILT_LEN    = 4;

    // True when a level change in the given direction should be reported.
    function automatic logic edge_enabled(input logic [1:0] mode, input logic rise);
        if (mode == MODE_OFF)
            return 1'b0;
        if (rise)
            return (mode == MODE_RISE) || (mode == MODE_BOTH);
        return (mode == MODE_FALL) || (mode == MODE_BOTH);
    endfunction

endpackage

// File: rtl/edge_channel.sv
// One detector channel: synchroniser, debounce filter (only when EDGE_DEBOUNCE_EN
// is defined; otherwise level follows sync one edge later), edge decode, sticky flag.
module edge_channel
    import edge_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
`ifdef EDGE_DEBOUNCE_EN
  , parameter int FILT_LEN    = DEF_FILT_LEN
`endif
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       din,
    input  logic [1:0] mode,
    input  logic       clr,
    output logic       pulse,
    output logic       level,
    output logic       flag
);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   sync;
    logic                   level_reg;
    logic                   pulse_reg;
    logic                   flag_reg;
    logic                   accept;
    logic                   pulse_next;
    logic                   flag_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sync_reg <= '0;
        else
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], din};
    end

    assign sync = sync_reg[SYNC_STAGES-1];

`ifdef EDGE_DEBOUNCE_EN
    localparam int CW = $clog2(FILT_LEN + 1);

    logic [CW-1:0] cnt_reg;
    logic [CW-1:0] cnt_next;

    // Count consecutive cycles of disagreement; the edge that would reach
    // FILT_LEN flips the level instead and restarts the count.
    always_comb begin
        cnt_next = '0;
        accept   = 1'b0;
        if (sync != level_reg) begin
            if (cnt_reg == CW'(FILT_LEN - 1))
                accept = 1'b1;
            else
                cnt_next = cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_reg <= '0;
        else
            cnt_reg <= cnt_next;
    end
`else
    assign accept = (sync != level_reg);
`endif

    // Direction is taken from the level before it flips.
    assign pulse_next = accept && edge_enabled(mode, !level_reg);
    // Holding the set term through the pulse cycle lets set beat a clear
    // that arrives while the strobe is visible.
    assign flag_next  = (flag_reg & ~clr) | pulse_next | pulse_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_reg <= 1'b0;
            pulse_reg <= 1'b0;
            flag_reg  <= 1'b0;
        end else begin
            level_reg <= level_reg ^ accept;
            pulse_reg <= pulse_next;
            flag_reg  <= flag_next;
        end
    end

    assign level = level_reg;
    assign pulse = pulse_reg;
    assign flag  = flag_reg;

endmodule

// File: rtl/edge_detect_bank.sv
// Bank of CH independent edge detector channels with a shared interrupt.
// Debounce filtering is included only when EDGE_DEBOUNCE_EN is defined.
module edge_detect_bank
    import edge_pkg::*;
#(
    parameter int CH          = DEF_CH,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int FILT_LEN    = DEF_FILT_LEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [CH-1:0]   din,
    input  logic [2*CH-1:0] mode,
    input  logic [CH-1:0]   clr,
    input  logic [CH-1:0]   irq_en,
    output logic [CH-1:0]   pulse,
    output logic [CH-1:0]   level,
    output logic [CH-1:0]   flags,
    output logic            irq
);

    logic irq_reg;

    if (CH < 1 || CH > 32 || SYNC_STAGES < 2 || FILT_LEN < 1 || FILT_LEN > 255) begin : g_bad_cfg
        $error("edge_detect_bank: parameter out of range");
    end

    for (genvar gi = 0; gi < CH; gi++) begin : g_ch
        edge_channel #(
            .SYNC_STAGES (SYNC_STAGES)
`ifdef EDGE_DEBOUNCE_EN
          , .FILT_LEN    (FILT_LEN)
`endif
        ) u_ch (
            .clk   (clk),
            .rst_n (rst_n),
            .din   (din[gi]),
            .mode  (mode[2*gi +: 2]),
            .clr   (clr[gi]),
            .pulse (pulse[gi]),
            .level (level[gi]),
            .flag  (flags[gi])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            irq_reg <= 1'b0;
        else
            irq_reg <= |(flags & irq_en);
    end

    assign irq = irq_reg;

endmodule

// File: doc/edge_detect_bank.md
EDGE_DETECT_BANK -- requirements
Module: edge_detect_bank

Interface
REQ-001 Parameter CH, default 8: number of independent input channels, legal range 1..32.
REQ-002 Parameter SYNC_STAGES, default 2: synchroniser flops per channel, minimum 2.
REQ-003 Parameter FILT_LEN, default 4: consecutive stable cycles required to accept a level change, range 1..255.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 din  input  CH  asynchronous raw channel levels.
REQ-007 mode  input  2*CH  per-channel detect mode, bits [2i+1:2i]: 00 off, 01 rise, 10 fall, 11 both.
REQ-008 clr  input  CH  write-1-to-clear for the matching sticky flag, sampled each cycle.
REQ-009 irq_en  input  CH  per-channel interrupt enable.
REQ-010 pulse  output  CH  registered one-cycle strobe per accepted, mode-enabled edge.
REQ-011 level  output  CH  filtered, synchronised channel level.
REQ-012 flags  output  CH  sticky event flags.
REQ-013 irq  output  1  registered OR of (flags & irq_en).

Function
REQ-014 Each channel SHALL pass din through a SYNC_STAGES-deep flop chain; only the chain output (sync) is used downstream.
REQ-015 Each channel SHALL hold a mismatch counter of width clog2(FILT_LEN+1): cleared when sync equals level, incremented when they differ.
REQ-016 level SHALL toggle on the edge where the counter would reach FILT_LEN; the counter then clears.
REQ-017 A sync excursion shorter than FILT_LEN cycles SHALL produce no level change, pulse, or flag.
REQ-018 A level 0->1 transition is a rise and 1->0 is a fall; pulse[i] SHALL be 1 for exactly the cycle following the level update when mode[i] enables that edge type.
REQ-019 Latency: with din stable from before edge 1, level and pulse SHALL become visible after edge SYNC_STAGES+FILT_LEN (edge 6 at defaults), and pulse SHALL drop after the next edge.
REQ-020 Mode 00 SHALL suppress pulse and flag only; filtering and level SHALL keep tracking.
REQ-021 A mode change SHALL take effect at the next clock edge and SHALL NOT reset the filter.
REQ-022 flags[i] SHALL set on pulse[i] and hold until clr[i]=1; when set and clear coincide in the same cycle, set SHALL win.
REQ-023 irq SHALL update one cycle after flags or irq_en change.
REQ-024 Channels SHALL be fully independent; simultaneous events on any number of channels SHALL all be reported in the same cycle.

Reset
REQ-025 While rst_n=0, all sync flops, counters, level, pulse, flags and irq SHALL be 0 immediately, regardless of clk.
REQ-026 After release, a channel whose din is held high SHALL report a rise after the normal latency.
REQ-027 Reset asserted mid-filter SHALL discard the partial count; no pulse from the pre-reset activity SHALL appear after release.

Configuration
REQ-028 Macro EDGE_DEBOUNCE_EN defined: the counter filter of REQ-015..017 is present.
REQ-029 Macro EDGE_DEBOUNCE_EN undefined: no counters; FILT_LEN is ignored; level SHALL register sync directly, with latency SYNC_STAGES+1 edges (3 at defaults); all other behaviour is unchanged.

Structure
REQ-030 Shared package edge_pkg SHALL hold the mode encodings MODE_OFF, MODE_RISE, MODE_FALL and MODE_BOTH, plus the default parameter constants.
REQ-031 Per-channel logic (synchroniser, filter, edge decode, flag) SHALL live in sub-module edge_channel, generated CH times; the top contains only the irq reduction.

Verification
REQ-032 Defaults, mode ch0=01: din[0] 0->1 held -> pulse[0]=1 only during the cycle after edge 6; flags[0]=1 after edge 6; irq=1 after edge 7 if irq_en[0]=1.
REQ-033 Defaults: din[1] high for 3 cycles then low -> level[1], pulse[1] and flags[1] stay 0.
REQ-034 mode ch2=11: din[2] rise then fall, 10 cycles apart -> two single-cycle pulses 10 cycles apart.
REQ-035 clr[3]=1 in the same cycle as pulse[3] -> flags[3] remains 1; clr[3]=1 in a later cycle -> flags[3]=0 after the next edge.
REQ-036 rst_n pulsed low at cycle 4 of a filter count -> all outputs 0 at once; after release with din=0, no pulse.
REQ-037 Build without EDGE_DEBOUNCE_EN: din[0] 0->1 -> pulse[0] visible after edge 3; a 1-cycle glitch produces a pulse.
